// File: rtl/inst_buffer_if.sv
// Fetch-to-decode handshake bundle: ICache response lanes in, decode lanes out.
interface inst_buffer_if #(
  parameter int unsigned FETCH_WIDTH  = 4,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned VALEN        = 32
);
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ECODE_W = 6;
  localparam int unsigned SUB_W   = 9;

  // Fetch side
  logic [FETCH_WIDTH-1:0]         in_valid;
  logic                           in_ready;
  logic [FETCH_WIDTH*VALEN-1:0]   in_vaddr;
  logic [FETCH_WIDTH*INSTR_W-1:0] in_instr;
  logic                           in_excp_valid;
  logic [ECODE_W-1:0]             in_excp_ecode;
  logic [SUB_W-1:0]               in_excp_sub;

  // Decode side
  logic [DECODE_WIDTH-1:0]         out_valid;
  logic [DECODE_WIDTH*VALEN-1:0]   out_vaddr;
  logic [DECODE_WIDTH*INSTR_W-1:0] out_instr;
  logic [DECODE_WIDTH-1:0]         out_excp_valid;
  logic [DECODE_WIDTH*ECODE_W-1:0] out_excp_ecode;
  logic [DECODE_WIDTH*SUB_W-1:0]   out_excp_sub;
  logic                            out_ready;

  // Environment view: drives fetch lanes and decode ready
  modport master (
    output in_valid, in_vaddr, in_instr, in_excp_valid, in_excp_ecode, in_excp_sub, out_ready,
    input  in_ready, out_valid, out_vaddr, out_instr, out_excp_valid, out_excp_ecode, out_excp_sub
  );

  // Buffer view
  modport slave (
    input  in_valid, in_vaddr, in_instr, in_excp_valid, in_excp_ecode, in_excp_sub, out_ready,
    output in_ready, out_valid, out_vaddr, out_instr, out_excp_valid, out_excp_ecode, out_excp_sub
  );
endinterface

// File: rtl/inst_buffer.sv
// Instruction queue between ICache response and decode: compacts valid fetch lanes,
// presents the oldest DECODE_WIDTH entries, carries fetch exceptions per entry.
module inst_buffer #(
  parameter int unsigned FETCH_WIDTH  = 4,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned VALEN        = 32
) (
  input  logic         clk,
  input  logic         a_rst_n,
  input  logic         flush_i,
  inst_buffer_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ECODE_W = 6;
  localparam int unsigned SUB_W   = 9;

  typedef struct packed {
    logic [VALEN-1:0]   vaddr;
    logic [INSTR_W-1:0] instr;
    logic               excp_valid;
    logic [ECODE_W-1:0] ecode;
    logic [SUB_W-1:0]   sub;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic                    in_ready_c;
  logic                    push_fire_c;
  logic [CNT_W-1:0]        n_push_c;
  logic [CNT_W-1:0]        n_pop_c;
  logic [PTR_W-1:0]        wptr_c;
  logic [DECODE_WIDTH-1:0] out_valid_c;

  // Room for a whole fetch group, judged on the registered count only
  assign in_ready_c   = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign bus.in_ready = in_ready_c;

  // Read side: lane i shows entry head+i straight from the array
  always_comb begin
    out_valid_c        = '0;
    bus.out_vaddr      = '0;
    bus.out_instr      = '0;
    bus.out_excp_valid = '0;
    bus.out_excp_ecode = '0;
    bus.out_excp_sub   = '0;
    n_pop_c            = '0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      out_valid_c[i]                         = (count_q > CNT_W'(i));
      bus.out_vaddr[i*VALEN +: VALEN]        = mem_q[head_q + PTR_W'(i)].vaddr;
      bus.out_instr[i*INSTR_W +: INSTR_W]    = mem_q[head_q + PTR_W'(i)].instr;
      bus.out_excp_valid[i]                  = mem_q[head_q + PTR_W'(i)].excp_valid;
      bus.out_excp_ecode[i*ECODE_W +: ECODE_W] = mem_q[head_q + PTR_W'(i)].ecode;
      bus.out_excp_sub[i*SUB_W +: SUB_W]     = mem_q[head_q + PTR_W'(i)].sub;
      if (out_valid_c[i] && bus.out_ready) begin
        n_pop_c = n_pop_c + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_c;

  // Write side: squeeze valid lanes into consecutive slots; an exception keeps only the first
  always_comb begin
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    n_push_c    = '0;
    wptr_c      = tail_q;
    push_fire_c = (|bus.in_valid) && in_ready_c && !flush_i;
    for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
      if (push_fire_c && bus.in_valid[l] && !(bus.in_excp_valid && (n_push_c != '0))) begin
        mem_d[wptr_c] = '{vaddr:      bus.in_vaddr[l*VALEN +: VALEN],
                          instr:      bus.in_instr[l*INSTR_W +: INSTR_W],
                          excp_valid: bus.in_excp_valid,
                          ecode:      bus.in_excp_ecode,
                          sub:        bus.in_excp_sub};
        wptr_c   = wptr_c + PTR_W'(1);
        n_push_c = n_push_c + CNT_W'(1);
      end
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_pop_c);
      tail_d  = wptr_c;
      count_d = count_q + n_push_c - n_pop_c;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: stimulus queues expected entries, monitor checks decode lanes.
module tb_inst_buffer;
  localparam int unsigned FW    = 4;
  localparam int unsigned DW    = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned VALEN = 32;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] instr;
    logic        ev;
    logic [5:0]  ec;
    logic [8:0]  sub;
  } ent_t;

  logic clk     = 1'b0;
  logic a_rst_n = 1'b0;
  logic flush_i = 1'b0;

  ent_t exp_q[$];
  ent_t m_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  inst_buffer_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .VALEN(VALEN)) bus ();

  inst_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .VALEN(VALEN)) dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .flush_i (flush_i),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a;
  endfunction

  // Monitor: lane valids follow scoreboard depth; consumed lanes must match oldest entries
  always @(negedge clk) begin
    if (a_rst_n) begin
      check("out_valid", 64'(bus.out_valid),
            (exp_q.size() >= 2) ? 64'd3 : (exp_q.size() == 1) ? 64'd1 : 64'd0);
      if (bus.out_ready && !flush_i) begin
        for (int i = 0; i < DW; i++) begin
          if (bus.out_valid[i] && exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            check("lane_vaddr", 64'(bus.out_vaddr[i*32 +: 32]), 64'(m_e.vaddr));
            check("lane_instr", 64'(bus.out_instr[i*32 +: 32]), 64'(m_e.instr));
            check("lane_excp_valid", 64'(bus.out_excp_valid[i]), 64'(m_e.ev));
            if (m_e.ev) begin
              check("lane_ecode", 64'(bus.out_excp_ecode[i*6 +: 6]), 64'(m_e.ec));
              check("lane_sub", 64'(bus.out_excp_sub[i*9 +: 9]), 64'(m_e.sub));
            end
          end
        end
      end
    end
  end

  // Drive one fetch group for one cycle; queue what should be stored if it is accepted
  task automatic push_group(input logic [3:0] v, input logic [31:0] base,
                            input logic ex, input logic [5:0] ec, input logic [8:0] sub);
    logic exp_rdy;
    bit   taken;
    ent_t e;
    exp_rdy = ((DEPTH - exp_q.size()) >= FW);
    bus.in_valid      = v;
    bus.in_excp_valid = ex;
    bus.in_excp_ecode = ec;
    bus.in_excp_sub   = sub;
    for (int l = 0; l < FW; l++) begin
      bus.in_vaddr[l*32 +: 32] = base + 32'(4 * l);
      bus.in_instr[l*32 +: 32] = instr_of(base + 32'(4 * l));
    end
    #1;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (exp_rdy && !flush_i) begin
      taken = 1'b0;
      for (int l = 0; l < FW; l++) begin
        if (v[l] && !(ex && taken)) begin
          e.vaddr = base + 32'(4 * l);
          e.instr = instr_of(e.vaddr);
          e.ev    = ex;
          e.ec    = ec;
          e.sub   = sub;
          exp_q.push_back(e);
          taken = 1'b1;
        end
      end
    end
    #1;
    bus.in_valid      = '0;
    bus.in_excp_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid      = '0;
    bus.in_vaddr      = '0;
    bus.in_instr      = '0;
    bus.in_excp_valid = 1'b0;
    bus.in_excp_ecode = '0;
    bus.in_excp_sub   = '0;
    bus.out_ready     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Full group visible next cycle, oldest first
    push_group(4'b1111, 32'h1c00_0000, 1'b0, 6'd0, 9'd0);
    check("t1_out_valid", 64'(bus.out_valid), 64'd3);
    check("t1_vaddr0", 64'(bus.out_vaddr[31:0]), 64'h1c00_0000);
    check("t1_vaddr1", 64'(bus.out_vaddr[63:32]), 64'h1c00_0004);
    drain();

    // Sparse lanes compacted
    push_group(4'b1010, 32'h1c00_0010, 1'b0, 6'd0, 9'd0);
    check("t2_out_valid", 64'(bus.out_valid), 64'd3);
    check("t2_vaddr0", 64'(bus.out_vaddr[31:0]), 64'h1c00_0014);
    check("t2_vaddr1", 64'(bus.out_vaddr[63:32]), 64'h1c00_001c);
    drain();

    // Fill to 12 while stalled, then 13 blocks input
    push_group(4'b1111, 32'h1c00_0100, 1'b0, 6'd0, 9'd0);
    push_group(4'b1111, 32'h1c00_0110, 1'b0, 6'd0, 9'd0);
    push_group(4'b1111, 32'h1c00_0120, 1'b0, 6'd0, 9'd0);
    check("t3_ready_at12", 64'(bus.in_ready), 64'd1);
    push_group(4'b0001, 32'h1c00_0130, 1'b0, 6'd0, 9'd0);
    check("t3_ready_at13", 64'(bus.in_ready), 64'd0);
    push_group(4'b1111, 32'h1c00_0140, 1'b0, 6'd0, 9'd0);
    check("t3_still_blocked", 64'(bus.in_ready), 64'd0);
    check("t3_head", 64'(bus.out_vaddr[31:0]), 64'h1c00_0100);
    drain();

    // Exception keeps only the lowest valid lane
    push_group(4'b1111, 32'h1c00_0200, 1'b1, 6'h3, 9'h05);
    check("t4_out_valid", 64'(bus.out_valid), 64'd1);
    check("t4_excp_valid", 64'(bus.out_excp_valid[0]), 64'd1);
    check("t4_ecode", 64'(bus.out_excp_ecode[5:0]), 64'h3);
    drain();

    // Steady push 2 / pop 2 across the pointer wrap
    push_group(4'b1111, 32'h1c00_0300, 1'b0, 6'd0, 9'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_group(4'b0011, 32'h1c00_0400 + 32'(16 * k), 1'b0, 6'd0, 9'd0);
    end
    check("t5_out_valid", 64'(bus.out_valid), 64'd3);
    drain();

    // Flush beats a same-cycle push and pop
    push_group(4'b1111, 32'h1c00_0500, 1'b0, 6'd0, 9'd0);
    flush_i       = 1'b1;
    bus.out_ready = 1'b1;
    push_group(4'b1111, 32'h1c00_0600, 1'b0, 6'd0, 9'd0);
    exp_q.delete();
    flush_i       = 1'b0;
    bus.out_ready = 1'b0;
    check("t6_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-operation
    push_group(4'b1111, 32'h1c00_0700, 1'b0, 6'd0, 9'd0);
    @(negedge clk);
    #2;
    a_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t7_out_valid", 64'(bus.out_valid), 64'd0);
    check("t7_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    #1;
    a_rst_n = 1'b1;
    push_group(4'b0100, 32'h1c00_0800, 1'b0, 6'd0, 9'd0);
    check("t7_after_vaddr", 64'(bus.out_vaddr[31:0]), 64'h1c00_0808);
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
